// File: rtl/ftoi.sv
// ftoi: 2-stage IEEE-754 single to signed 32-bit integer converter with valid/ready handshake.
// Truncates toward zero by default; define FTOI_ROUND_NEAREST_EN for round-to-nearest-even.
module ftoi (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);
    logic        s1_valid, s2_valid, s1_load, s2_load;
    logic        s1_neg, s1_sat;
    logic [32:0] s1_mag;
    logic [7:0]  e;
    logic        in_rng, neg_d, sat_d;
    logic [32:0] mag_d, r, sv;
    logic [31:0] res;
`ifdef FTOI_ROUND_NEAREST_EN
    logic        s1_g, s1_st;
    logic [54:0] x;
`endif
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;
    always_comb begin
        e      = a[30:23];
        in_rng = e >= 8'd126 && e <= 8'd157;
        // NaN reports as positive so it saturates to the max positive value
        neg_d  = a[31] && !(e == 8'hFF && |a[22:0]);
        sat_d  = e >= 8'd158;
`ifdef FTOI_ROUND_NEAREST_EN
        // 24 fraction bits below the integer part carry guard and sticky
        x      = in_rng ? {31'b0, 1'b1, a[22:0]} << (e - 8'd126) : 55'b0;
        mag_d  = {2'b0, x[54:24]};
`else
        mag_d  = !in_rng ? 33'b0 :
                 e >= 8'd150 ? {9'b0, 1'b1, a[22:0]} << (e - 8'd150) :
                               {9'b0, 1'b1, a[22:0]} >> (8'd150 - e);
`endif
    end
    always_comb begin
`ifdef FTOI_ROUND_NEAREST_EN
        r   = s1_mag + {32'b0, s1_g & (s1_st | s1_mag[0])};
`else
        r   = s1_mag;
`endif
        sv  = s1_neg ? -r : r;
        // a 33-bit signed value outside the 32-bit range shows as differing top bits
        res = (s1_sat || (sv[32] ^ sv[31])) ? (s1_neg ? 32'h80000000 : 32'h7FFFFFFF) : sv[31:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            c        <= 32'h0;
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) c <= res;
        end
    end
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_neg <= neg_d;
            s1_sat <= sat_d;
            s1_mag <= mag_d;
`ifdef FTOI_ROUND_NEAREST_EN
            s1_g   <= x[23];
            s1_st  <= |x[22:0];
`endif
        end
    end
endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi: directed-vector bench for ftoi; expected values hand-computed per rounding build.
module tb_ftoi;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] a = 32'h0, c;
    int          checks = 0, failures = 0;
    logic [31:0] vin[$], vexp[$];

    ftoi dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
              .out_valid(out_valid), .out_ready(out_ready), .c(c));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] v, input logic [31:0] x);
        vin.push_back(v);
        vexp.push_back(x);
    endtask

    // feeds vin, collects outputs in order; pipeline occupancy predicts in_ready
    task automatic stream(input string tag, input bit rnd);
        int n = vin.size();
        int sent = 0, rcv = 0;
        for (int cyc = 0; cyc < 300 && rcv < n; cyc++) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = sent < n;
            a         = sent < n ? vin[sent] : 32'h0;
            #1;
            chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(sent - rcv == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                chk($sformatf("%s_c%0d", tag, rcv), c, vexp[rcv]);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk({tag, "_count"}, 32'(rcv), 32'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk({tag, "_idle"}, 32'(out_valid), 32'd0);
        end
        vin.delete();
        vexp.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // back-to-back pi / -pi with exact 2-cycle latency
        @(negedge clk);
        in_valid = 1'b1; a = 32'h40490FDB;
        @(negedge clk);
        a = 32'hC0490FDB;
        #1 chk("lat_ov0", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("lat_ov1", 32'(out_valid), 32'd1);
        chk("lat_pi", c, 32'd3);
        @(negedge clk); #1;
        chk("lat_ov2", 32'(out_valid), 32'd1);
        chk("lat_npi", c, 32'hFFFFFFFD);
        @(negedge clk); #1;
        chk("lat_ov3", 32'(out_valid), 32'd0);

`ifdef FTOI_ROUND_NEAREST_EN
        add(32'h3FC00000, 32'd2);
        add(32'h40200000, 32'd2);
        add(32'hBF000000, 32'd0);
        add(32'h40600000, 32'd4);
        add(32'h3F7FFFFF, 32'd1);
`else
        add(32'h3FC00000, 32'd1);
        add(32'h40200000, 32'd2);
        add(32'hBF000000, 32'd0);
        add(32'h40600000, 32'd3);
        add(32'h3F7FFFFF, 32'd0);
`endif
        add(32'h3F000000, 32'd0);
        stream("round", 1'b0);

        add(32'h4F000000, 32'h7FFFFFFF);
        add(32'hCF000000, 32'h80000000);
        add(32'h7FC00000, 32'h7FFFFFFF);
        add(32'hFF800000, 32'h80000000);
        add(32'hFFC00000, 32'h7FFFFFFF);
        stream("sat", 1'b0);

        add(32'h3F800000, 32'd1);
        add(32'hC2F60000, 32'hFFFFFF85);
        add(32'h4B000001, 32'h00800001);
        add(32'h7F800000, 32'h7FFFFFFF);
        add(32'h00000001, 32'd0);
        add(32'h4EFFFFFF, 32'h7FFFFF80);
        add(32'hCEFFFFFF, 32'h80000080);
        add(32'h461C4000, 32'd10000);
        stream("bp", 1'b1);

        // reset with two operands in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'h3FC00000;
        @(negedge clk);
        a = 32'h40200000;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("pre_rst_ov", 32'(out_valid), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_c", c, 32'h0);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post_rst_ov", 32'(out_valid), 32'd0);
        end
        add(32'h41200000, 32'd10);
        stream("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
